window_buffer: RTL and testbench

- Parametrised successor to the fixed 4-entry byte buffer: DEPTH entries of WIDTH bits.
- Presents all entries packed on one flat output bus for downstream datapath or filter logic.
- Per-entry valid tracking and a valid/ready output handshake.
- Two fill modes: addressed random write, or shift-in sliding window with configurable STRIDE.

---
 rtl/window_buffer.sv | 114 +++++++++++
 tb/tb_window_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/window_buffer.sv
// window_buffer: DEPTH x WIDTH entry buffer exposed as one flat bus.
// Supports addressed random writes or a shift-in sliding window whose
// consumed windows release the STRIDE oldest entries.
module window_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  input  logic                    mode,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       address,
  input  logic [WIDTH-1:0]        data_in,
  output logic                    in_ready,
  output logic [WIDTH*DEPTH-1:0]  data_out,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic [ADDR_W:0]         count,
  output logic                    overrun
);

  logic [WIDTH-1:0] entry_reg  [DEPTH];
  logic [WIDTH-1:0] entry_next [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] valid_kept;
  logic [DEPTH-1:0] clear_mask;
  logic             overrun_reg;
  logic             accept;
  logic             handshake;
  logic             addr_ok;
  logic [ADDR_W:0]  count_sum;

  assign data_valid = &valid_reg;
  assign in_ready   = ~data_valid | data_ready;
  assign accept     = write & in_ready;
  assign handshake  = data_valid & data_ready;
  assign overrun    = overrun_reg;
  assign count      = count_sum;

  // Out-of-range addresses are silently dropped.
  assign addr_ok = ({1'b0, address} < (ADDR_W+1)'(DEPTH));

  // A consumed window releases its clear before any same-cycle write lands.
  assign valid_kept = handshake ? (valid_reg & ~clear_mask) : valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // buf[0] sits in the most significant slice of the flat bus.
      assign data_out[(DEPTH-1-gi)*WIDTH +: WIDTH] = entry_reg[gi];

      // Addressed mode clears every entry; shift mode only the oldest STRIDE.
      assign clear_mask[gi] = mode ? ((gi < STRIDE) ? 1'b1 : 1'b0) : 1'b1;

      if (gi < DEPTH-1) begin : g_mid
        // Next value of an inner entry: shift from its newer neighbour or addressed write.
        always_comb begin
          entry_next[gi] = entry_reg[gi];
          valid_next[gi] = valid_kept[gi];
          if (accept && mode) begin
            entry_next[gi] = entry_reg[gi+1];
            valid_next[gi] = valid_kept[gi+1];
          end else if (accept && !mode && addr_ok && (address == ADDR_W'(gi))) begin
            entry_next[gi] = data_in;
            valid_next[gi] = 1'b1;
          end
        end
      end else begin : g_last
        // Next value of the newest entry: takes data_in on a shift or addressed write.
        always_comb begin
          entry_next[gi] = entry_reg[gi];
          valid_next[gi] = valid_kept[gi];
          if (accept && mode) begin
            entry_next[gi] = data_in;
            valid_next[gi] = 1'b1;
          end else if (accept && !mode && addr_ok && (address == ADDR_W'(gi))) begin
            entry_next[gi] = data_in;
            valid_next[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  // Population count of the valid bits; bounded by DEPTH so it cannot wrap.
  always_comb begin
    count_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_sum = count_sum + (ADDR_W+1)'(valid_reg[i]);
    end
  end

  // State register: async reset, then synchronous init, then normal update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
      valid_reg   <= '0;
      overrun_reg <= 1'b0;
    end else if (init) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
      valid_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
      valid_reg <= valid_next;
      if (write && !in_ready) overrun_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer: table-driven vectors through a scoreboard queue,
// plus hand-written sequences for STRIDE=2 and asynchronous reset.
module tb_window_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic        mode = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  address = '0;
  logic [7:0]  data_in = '0;
  logic        data_ready = 1'b0;

  logic        in_ready1, data_valid1, overrun1;
  logic [31:0] data_out1;
  logic [2:0]  count1;
  logic        in_ready2, data_valid2, overrun2;
  logic [31:0] data_out2;
  logic [2:0]  count2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  window_buffer #(.WIDTH(8), .DEPTH(4), .STRIDE(1), .ADDR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .init(init), .mode(mode), .write(write),
    .address(address), .data_in(data_in), .in_ready(in_ready1),
    .data_out(data_out1), .data_valid(data_valid1), .data_ready(data_ready),
    .count(count1), .overrun(overrun1)
  );

  window_buffer #(.WIDTH(8), .DEPTH(4), .STRIDE(2), .ADDR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .init(init), .mode(mode), .write(write),
    .address(address), .data_in(data_in), .in_ready(in_ready2),
    .data_out(data_out2), .data_valid(data_valid2), .data_ready(data_ready),
    .count(count2), .overrun(overrun2)
  );

  typedef struct packed {
    logic [31:0] dout;
    logic        valid;
    logic [2:0]  cnt;
    logic        ovr;
  } exp_t;

  typedef struct packed {
    logic       init;
    logic       mode;
    logic       write;
    logic [1:0] addr;
    logic [7:0] din;
    logic       dr;
    logic       rdy;   // expected in_ready before the edge
    exp_t       e;     // expected outputs after the edge
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[14];

  function automatic vec_t mkv(input logic i, input logic m, input logic w,
                               input logic [1:0] a, input logic [7:0] d,
                               input logic dr, input logic rdy,
                               input logic [31:0] dout, input logic v,
                               input logic [2:0] c, input logic o);
    vec_t r;
    r.init = i; r.mode = m; r.write = w; r.addr = a; r.din = d; r.dr = dr;
    r.rdy = rdy; r.e.dout = dout; r.e.valid = v; r.e.cnt = c; r.e.ovr = o;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic i, input logic m, input logic w, input logic [1:0] a,
                       input logic [7:0] d, input logic dr);
    @(negedge clk);
    init = i; mode = m; write = w; address = a; data_in = d; data_ready = dr;
  endtask

  // Compare one popped expectation against the STRIDE=2 instance.
  task automatic pop_check2(input string name);
    exp_t e;
    e = exp_q.pop_front();
    check({name, "_dout"},  data_out2, e.dout);
    check({name, "_valid"}, 32'(data_valid2), 32'(e.valid));
    check({name, "_count"}, 32'(count2), 32'(e.cnt));
  endtask

  initial begin
    // Table: addressed fill, handshake+write, init, shift fill, overrun, init.
    vecs[0]  = mkv(0,0,1,2'd3,8'h11,0, 1, 32'h00000011,0,3'd1,0);
    vecs[1]  = mkv(0,0,1,2'd2,8'h22,0, 1, 32'h00002211,0,3'd2,0);
    vecs[2]  = mkv(0,0,1,2'd1,8'h33,0, 1, 32'h00332211,0,3'd3,0);
    vecs[3]  = mkv(0,0,1,2'd0,8'h44,0, 1, 32'h44332211,1,3'd4,0);
    vecs[4]  = mkv(0,0,1,2'd2,8'h55,1, 1, 32'h44335511,0,3'd1,0);
    vecs[5]  = mkv(1,1,1,2'd0,8'hEE,1, 1, 32'h00000000,0,3'd0,0);
    vecs[6]  = mkv(0,1,1,2'd0,8'h01,1, 1, 32'h00000001,0,3'd1,0);
    vecs[7]  = mkv(0,1,1,2'd3,8'h02,1, 1, 32'h00000102,0,3'd2,0);
    vecs[8]  = mkv(0,1,1,2'd1,8'h03,1, 1, 32'h00010203,0,3'd3,0);
    vecs[9]  = mkv(0,1,1,2'd2,8'h04,1, 1, 32'h01020304,1,3'd4,0);
    vecs[10] = mkv(0,1,1,2'd0,8'h05,1, 1, 32'h02030405,1,3'd4,0);
    vecs[11] = mkv(0,1,1,2'd0,8'h99,0, 0, 32'h02030405,1,3'd4,1);
    vecs[12] = mkv(0,1,0,2'd0,8'h00,0, 0, 32'h02030405,1,3'd4,1);
    vecs[13] = mkv(1,0,0,2'd0,8'h00,0, 0, 32'h00000000,0,3'd0,0);

    // Reset state while rst_n is held low, before any clock edge.
    #2;
    check("rst_dout",  data_out1, 32'h0);
    check("rst_valid", 32'(data_valid1), 32'h0);
    check("rst_count", 32'(count1), 32'h0);
    check("rst_ready", 32'(in_ready1), 32'h1);
    check("rst_ovr",   32'(overrun1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 14; k++) begin
      exp_t e;
      drive(vecs[k].init, vecs[k].mode, vecs[k].write, vecs[k].addr, vecs[k].din, vecs[k].dr);
      #1;
      check($sformatf("v%0d_in_ready", k), 32'(in_ready1), 32'(vecs[k].rdy));
      exp_q.push_back(vecs[k].e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_dout", k),  data_out1, e.dout);
      check($sformatf("v%0d_valid", k), 32'(data_valid1), 32'(e.valid));
      check($sformatf("v%0d_count", k), 32'(count1), 32'(e.cnt));
      check($sformatf("v%0d_ovr", k),   32'(overrun1), 32'(e.ovr));
      $display("vec %0d: dout=%h valid=%0d count=%0d ovr=%0d", k, data_out1, data_valid1, count1, overrun1);
    end

    // STRIDE=2 sliding window: fill 1..4, consume, write 5, write 6.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 1, 2'd0, 8'(k), 0);
      @(posedge clk);
    end
    #1;
    exp_q.push_back('{dout:32'h01020304, valid:1'b1, cnt:3'd4, ovr:1'b0});
    pop_check2("s2_full");
    drive(0, 1, 0, 2'd0, 8'h00, 1);
    exp_q.push_back('{dout:32'h01020304, valid:1'b0, cnt:3'd2, ovr:1'b0});
    @(posedge clk); #1;
    pop_check2("s2_consume");
    drive(0, 1, 1, 2'd0, 8'h05, 0);
    exp_q.push_back('{dout:32'h02030405, valid:1'b0, cnt:3'd3, ovr:1'b0});
    @(posedge clk); #1;
    pop_check2("s2_w5");
    drive(0, 1, 1, 2'd0, 8'h06, 0);
    exp_q.push_back('{dout:32'h03040506, valid:1'b1, cnt:3'd4, ovr:1'b0});
    @(posedge clk); #1;
    pop_check2("s2_w6");
    $display("stride2: dout=%h valid=%0d count=%0d", data_out2, data_valid2, count2);

    // Asynchronous reset in the middle of an addressed fill.
    drive(1, 0, 0, 2'd0, 8'h00, 0);
    @(posedge clk);
    drive(0, 0, 1, 2'd0, 8'hAA, 0);
    @(posedge clk);
    drive(0, 0, 1, 2'd1, 8'hBB, 0);
    @(posedge clk); #1;
    check("mid_count", 32'(count1), 32'd2);
    write = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout",  data_out1, 32'h0);
    check("arst_count", 32'(count1), 32'h0);
    check("arst_valid", 32'(data_valid1), 32'h0);
    check("arst_ready", 32'(in_ready1), 32'h1);
    $display("async reset: dout=%h count=%0d", data_out1, count1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 2'd3, 8'hCC, 0);
    @(posedge clk); #1;
    check("post_count", 32'(count1), 32'd1);
    check("post_dout",  data_out1, 32'h000000CC);
    $display("after reset write: dout=%h count=%0d", data_out1, count1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
